c7blsu_ctl: RTL and testbench

Load/store control stage that sits directly upstream of the execution control logic. It accepts one memory op per `lsu_vld_e` and checks alignment in LS1. It then runs a single-outstanding valid/ready request and response on the data bus and returns the LS1/LS3 completion pulses (`lsu_except_ale_ls1`, `lsu_data_valid_ls3`, `lsu_wr_fin_ls3`, `lsu_except_buserr_ls3`) that the execution control logic uses to release its IFU and register-write stalls. Load data is lane-extracted and extended before write-back.

---
 rtl/c7b_lsu_pkg.sv | 25 ++
 rtl/c7blsu_align.sv | 47 ++++
 rtl/c7blsu_ctl.sv | 163 ++++++++++++++++
 tb/tb_c7blsu_ctl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/c7b_lsu_pkg.sv
// Shared definitions for the c7b load/store control stage.
// Holds the FSM state encoding, the access-size encodings and the bit
// positions of the fields inside the 4-bit memory op code.
package c7b_lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LS1  = 3'd1,
    ST_REQ  = 3'd2,
    ST_RSP  = 3'd3,
    ST_LS3  = 3'd4
  } lsu_state_e;

  // Access size field op[1:0]; 2'b11 is reserved and handled as a word.
  localparam logic [1:0] LSU_SZ_B = 2'b00;
  localparam logic [1:0] LSU_SZ_H = 2'b01;
  localparam logic [1:0] LSU_SZ_W = 2'b10;

  // Op code field positions.
  localparam int OP_ST_BIT = 3;  // 1 = store
  localparam int OP_ZX_BIT = 2;  // 1 = zero-extend load data
  localparam int OP_SZ_LSB = 0;
  localparam int OP_SZ_MSB = 1;

endpackage

// File: rtl/c7blsu_align.sv
// Combinational alignment / store lane formatter.
// Ports:
//   size      in  2  : access size (byte/half/word, reserved = word)
//   addr_lo   in  2  : low address bits selecting the byte lane
//   wdata     in  DW : raw store data, taken from the low bytes
//   misalign  out 1  : access does not sit on its natural boundary
//   wstrb     out 4  : byte enables for a store
//   wdata_rep out DW : store data replicated across all lanes
module c7blsu_align
  import c7b_lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]    size,
  input  logic [1:0]    addr_lo,
  input  logic [DW-1:0] wdata,
  output logic          misalign,
  output logic [3:0]    wstrb,
  output logic [DW-1:0] wdata_rep
);

  localparam int BW = DW / 4;

  always_comb begin
    misalign  = 1'b0;
    wstrb     = 4'b1111;
    wdata_rep = wdata;
    case (size)
      LSU_SZ_B: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[BW-1:0]}};
      end
      LSU_SZ_H: begin
        misalign  = addr_lo[0];
        // A half at lane 3 would shift out of range, but it is misaligned
        // and never reaches the bus.
        wstrb     = 4'b0011 << addr_lo;
        wdata_rep = {2{wdata[2*BW-1:0]}};
      end
      default: begin
        // Word and the reserved encoding.
        misalign = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/c7blsu_ctl.sv
// Load/store control stage: accepts one memory op, checks alignment in LS1,
// runs a single-outstanding valid/ready data-bus transaction and returns
// one-cycle completion pulses (ALE in LS1; load-valid, store-finished or
// bus-error in LS3). Load data is lane-extracted and extended.
// Ports:
//   clk, reset                  : clock, async active-high reset
//   lsu_vld_e/op_e/addr_e/...   : op issued from E
//   data_req_*                  : bus request channel (valid/ready)
//   data_rsp_*                  : bus response channel (always accepted)
//   lsu_except_ale_ls1          : misaligned-op pulse, with lsu_badaddr_ls1
//   lsu_data_valid_ls3          : load complete, with lsu_rdata_ls3/lsu_rd_ls3
//   lsu_wr_fin_ls3              : store complete
//   lsu_except_buserr_ls3       : bus error reported by the response
module c7blsu_ctl
  import c7b_lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          lsu_vld_e,
  input  logic [3:0]    lsu_op_e,
  input  logic [AW-1:0] lsu_addr_e,
  input  logic [DW-1:0] lsu_wdata_e,
  input  logic [4:0]    lsu_rd_e,
  output logic          data_req_valid,
  input  logic          data_req_ready,
  output logic [AW-1:0] data_req_addr,
  output logic          data_req_wr,
  output logic [3:0]    data_req_wstrb,
  output logic [DW-1:0] data_req_wdata,
  input  logic          data_rsp_valid,
  input  logic          data_rsp_err,
  input  logic [DW-1:0] data_rsp_rdata,
  output logic          lsu_except_ale_ls1,
  output logic          lsu_data_valid_ls3,
  output logic          lsu_wr_fin_ls3,
  output logic          lsu_except_buserr_ls3,
  output logic [DW-1:0] lsu_rdata_ls3,
  output logic [4:0]    lsu_rd_ls3,
  output logic [AW-1:0] lsu_badaddr_ls1
);

  lsu_state_e    state_reg;
  logic [3:0]    op_reg;
  logic [1:0]    addr_lo_reg;
  logic [4:0]    rd_reg;
  logic          misalign_reg;

  logic          misalign_e;
  logic [3:0]    wstrb_e;
  logic [DW-1:0] wdata_rep_e;

  // Formatting is done on the E-stage inputs so the ALE pulse and all
  // request fields can come straight out of flops.
  c7blsu_align #(.DW(DW)) u_align (
    .size      (lsu_op_e[OP_SZ_MSB:OP_SZ_LSB]),
    .addr_lo   (lsu_addr_e[1:0]),
    .wdata     (lsu_wdata_e),
    .misalign  (misalign_e),
    .wstrb     (wstrb_e),
    .wdata_rep (wdata_rep_e)
  );

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  logic [DW-1:0] rsp_shifted;
  logic [DW-1:0] load_ext;
  logic          zx;

  always_comb begin
    zx          = op_reg[OP_ZX_BIT];
    rsp_shifted = data_rsp_rdata >> {addr_lo_reg, 3'b000};
    case (op_reg[OP_SZ_MSB:OP_SZ_LSB])
      LSU_SZ_B: load_ext = {{(DW-8){rsp_shifted[7] & ~zx}}, rsp_shifted[7:0]};
      LSU_SZ_H: load_ext = {{(DW-16){rsp_shifted[15] & ~zx}}, rsp_shifted[15:0]};
      default:  load_ext = rsp_shifted;  // word: aligned, shift is zero
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg             <= ST_IDLE;
      op_reg                <= '0;
      addr_lo_reg           <= '0;
      rd_reg                <= '0;
      misalign_reg          <= 1'b0;
      data_req_valid        <= 1'b0;
      data_req_addr         <= '0;
      data_req_wr           <= 1'b0;
      data_req_wstrb        <= '0;
      data_req_wdata        <= '0;
      lsu_except_ale_ls1    <= 1'b0;
      lsu_data_valid_ls3    <= 1'b0;
      lsu_wr_fin_ls3        <= 1'b0;
      lsu_except_buserr_ls3 <= 1'b0;
      lsu_rdata_ls3         <= '0;
      lsu_rd_ls3            <= '0;
      lsu_badaddr_ls1       <= '0;
    end else begin
      // Completion outputs are single-cycle pulses by default.
      lsu_except_ale_ls1    <= 1'b0;
      lsu_data_valid_ls3    <= 1'b0;
      lsu_wr_fin_ls3        <= 1'b0;
      lsu_except_buserr_ls3 <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (lsu_vld_e) begin
            op_reg         <= lsu_op_e;
            addr_lo_reg    <= lsu_addr_e[1:0];
            rd_reg         <= lsu_rd_e;
            misalign_reg   <= misalign_e;
            data_req_addr  <= {lsu_addr_e[AW-1:2], 2'b00};
            data_req_wr    <= lsu_op_e[OP_ST_BIT];
            data_req_wstrb <= lsu_op_e[OP_ST_BIT] ? wstrb_e : 4'b0000;
            data_req_wdata <= lsu_op_e[OP_ST_BIT] ? wdata_rep_e : '0;
            if (misalign_e) begin
              // Registered here so the pulse is visible during LS1.
              lsu_except_ale_ls1 <= 1'b1;
              lsu_badaddr_ls1    <= lsu_addr_e;
            end
            state_reg <= ST_LS1;
          end
        end
        ST_LS1: begin
          if (misalign_reg) begin
            state_reg <= ST_IDLE;
          end else begin
            data_req_valid <= 1'b1;
            state_reg      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (data_req_ready) begin
            data_req_valid <= 1'b0;
            state_reg      <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (data_rsp_valid) begin
            if (data_rsp_err) begin
              lsu_except_buserr_ls3 <= 1'b1;
            end else if (op_reg[OP_ST_BIT]) begin
              lsu_wr_fin_ls3 <= 1'b1;
            end else begin
              lsu_data_valid_ls3 <= 1'b1;
              lsu_rdata_ls3      <= load_ext;
              lsu_rd_ls3         <= rd_reg;
            end
            state_reg <= ST_LS3;
          end
        end
        ST_LS3: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c7blsu_ctl.sv
// Table-driven bench for c7blsu_ctl with a completion scoreboard.
module tb_c7blsu_ctl;

  localparam int AW = 32;
  localparam int DW = 32;

  // Completion pattern {ale, data_valid, wr_fin, buserr}
  localparam logic [3:0] K_ALE = 4'b1000;
  localparam logic [3:0] K_DV  = 4'b0100;
  localparam logic [3:0] K_WF  = 4'b0010;
  localparam logic [3:0] K_BE  = 4'b0001;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          lsu_vld_e = 1'b0;
  logic [3:0]    lsu_op_e = '0;
  logic [AW-1:0] lsu_addr_e = '0;
  logic [DW-1:0] lsu_wdata_e = '0;
  logic [4:0]    lsu_rd_e = '0;
  logic          data_req_valid;
  logic          data_req_ready = 1'b0;
  logic [AW-1:0] data_req_addr;
  logic          data_req_wr;
  logic [3:0]    data_req_wstrb;
  logic [DW-1:0] data_req_wdata;
  logic          data_rsp_valid = 1'b0;
  logic          data_rsp_err = 1'b0;
  logic [DW-1:0] data_rsp_rdata = '0;
  logic          lsu_except_ale_ls1;
  logic          lsu_data_valid_ls3;
  logic          lsu_wr_fin_ls3;
  logic          lsu_except_buserr_ls3;
  logic [DW-1:0] lsu_rdata_ls3;
  logic [4:0]    lsu_rd_ls3;
  logic [AW-1:0] lsu_badaddr_ls1;

  c7blsu_ctl #(.AW(AW), .DW(DW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .lsu_vld_e             (lsu_vld_e),
    .lsu_op_e              (lsu_op_e),
    .lsu_addr_e            (lsu_addr_e),
    .lsu_wdata_e           (lsu_wdata_e),
    .lsu_rd_e              (lsu_rd_e),
    .data_req_valid        (data_req_valid),
    .data_req_ready        (data_req_ready),
    .data_req_addr         (data_req_addr),
    .data_req_wr           (data_req_wr),
    .data_req_wstrb        (data_req_wstrb),
    .data_req_wdata        (data_req_wdata),
    .data_rsp_valid        (data_rsp_valid),
    .data_rsp_err          (data_rsp_err),
    .data_rsp_rdata        (data_rsp_rdata),
    .lsu_except_ale_ls1    (lsu_except_ale_ls1),
    .lsu_data_valid_ls3    (lsu_data_valid_ls3),
    .lsu_wr_fin_ls3        (lsu_wr_fin_ls3),
    .lsu_except_buserr_ls3 (lsu_except_buserr_ls3),
    .lsu_rdata_ls3         (lsu_rdata_ls3),
    .lsu_rd_ls3            (lsu_rd_ls3),
    .lsu_badaddr_ls1       (lsu_badaddr_ls1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        err;
    int          rdy_dly;
    int          rsp_dly;
    logic [3:0]  kind;
    logic [31:0] exp_rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [3:0]  kind;
    int          due;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] badaddr;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  logic prev_any = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Completion monitor: pops the scoreboard on every pulse.
  always @(negedge clk) begin
    logic [3:0] p;
    exp_t       e;
    p = {lsu_except_ale_ls1, lsu_data_valid_ls3, lsu_wr_fin_ls3, lsu_except_buserr_ls3};
    if (p != 4'b0000) begin
      pulses++;
      chk("pulse_onehot", 32'($countones(p)), 32'd1);
      chk("pulse_not_back_to_back", 32'(prev_any), 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", 32'(p), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("pulse_kind", 32'(p), 32'(e.kind));
        chk("pulse_cycle", 32'(cyc), 32'(e.due));
        if (e.kind == K_DV) begin
          chk("rdata_ls3", lsu_rdata_ls3, e.rdata);
          chk("rd_ls3", 32'(lsu_rd_ls3), 32'(e.rd));
        end
        if (e.kind == K_ALE) chk("badaddr_ls1", lsu_badaddr_ls1, e.badaddr);
        $display("cycle %0d: completion %b rdata=0x%08h rd=%0d badaddr=0x%08h",
                 cyc, p, lsu_rdata_ls3, lsu_rd_ls3, lsu_badaddr_ls1);
      end
    end
    prev_any = (p != 4'b0000);
  end

  // Issue one op, drive the bus side, and push the expected completion.
  task automatic do_op(input vec_t v);
    exp_t e;
    int   t0;
    @(negedge clk);
    chk("idle_no_req", 32'(data_req_valid), 32'd0);
    lsu_vld_e   = 1'b1;
    lsu_op_e    = v.op;
    lsu_addr_e  = v.addr;
    lsu_wdata_e = v.wdata;
    lsu_rd_e    = v.rd;
    t0          = cyc;
    e.kind      = v.kind;
    e.due       = t0 + ((v.kind == K_ALE) ? 1 : (4 + v.rdy_dly + v.rsp_dly));
    e.rdata     = v.exp_rdata;
    e.rd        = v.rd;
    e.badaddr   = v.addr;
    sb_q.push_back(e);
    @(negedge clk);
    lsu_vld_e = 1'b0;
    chk("ls1_no_req", 32'(data_req_valid), 32'd0);
    if (v.kind == K_ALE) return;
    @(negedge clk);
    for (int k = 0; k <= v.rdy_dly; k++) begin
      chk("req_valid", 32'(data_req_valid), 32'd1);
      chk("req_addr", data_req_addr, v.exp_addr);
      chk("req_wr", 32'(data_req_wr), 32'(v.op[3]));
      chk("req_wstrb", 32'(data_req_wstrb), 32'(v.exp_wstrb));
      if (v.op[3]) chk("req_wdata", data_req_wdata, v.exp_wdata);
      data_req_ready = (k == v.rdy_dly);
      @(negedge clk);
    end
    data_req_ready = 1'b0;
    chk("req_dropped_after_ready", 32'(data_req_valid), 32'd0);
    for (int j = 0; j <= v.rsp_dly; j++) begin
      if (j == v.rsp_dly) begin
        data_rsp_valid = 1'b1;
        data_rsp_rdata = v.rdata;
        data_rsp_err   = v.err;
      end
      @(negedge clk);
    end
    data_rsp_valid = 1'b0;
    data_rsp_err   = 1'b0;
  endtask

  function automatic vec_t mk(
    input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
    input logic [4:0] rd, input logic [31:0] rdata, input logic err,
    input int rdy_dly, input int rsp_dly, input logic [3:0] kind,
    input logic [31:0] exp_rdata, input logic [31:0] exp_addr,
    input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.rd = rd; v.rdata = rdata;
    v.err = err; v.rdy_dly = rdy_dly; v.rsp_dly = rsp_dly; v.kind = kind;
    v.exp_rdata = exp_rdata; v.exp_addr = exp_addr;
    v.exp_wstrb = exp_wstrb; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  vec_t vt[14];
  int   pulses_before;

  initial begin
    //            op       addr          wdata         rd     rdata         err rdy rsp kind   exp_rdata     exp_addr      wstrb    exp_wdata
    vt[0]  = mk(4'b0010, 32'h0000_1000, 32'h0,        5'd5,  32'h80FF_1234, 0, 0, 0, K_DV,  32'h80FF_1234, 32'h0000_1000, 4'b0000, 32'h0);
    vt[1]  = mk(4'b0000, 32'h0000_1003, 32'h0,        5'd6,  32'h80FF_1234, 0, 0, 0, K_DV,  32'hFFFF_FF80, 32'h0000_1000, 4'b0000, 32'h0);
    vt[2]  = mk(4'b0100, 32'h0000_1003, 32'h0,        5'd7,  32'h80FF_1234, 0, 0, 0, K_DV,  32'h0000_0080, 32'h0000_1000, 4'b0000, 32'h0);
    vt[3]  = mk(4'b1001, 32'h0000_2002, 32'h0000_BEEF, 5'd0, 32'h0,         0, 3, 0, K_WF,  32'h0,         32'h0000_2000, 4'b1100, 32'hBEEF_BEEF);
    vt[4]  = mk(4'b0010, 32'h0000_3001, 32'h0,        5'd1,  32'h0,         0, 0, 0, K_ALE, 32'h0,         32'h0,         4'b0000, 32'h0);
    vt[5]  = mk(4'b1000, 32'h0000_4001, 32'h1234_565A, 5'd0, 32'h0,         0, 0, 2, K_WF,  32'h0,         32'h0000_4000, 4'b0010, 32'h5A5A_5A5A);
    vt[6]  = mk(4'b0001, 32'h0000_5002, 32'h0,        5'd8,  32'h1111_2222, 1, 0, 0, K_BE,  32'h0,         32'h0000_5000, 4'b0000, 32'h0);
    vt[7]  = mk(4'b0001, 32'h0000_6000, 32'h0,        5'd9,  32'h1234_8001, 0, 1, 1, K_DV,  32'hFFFF_8001, 32'h0000_6000, 4'b0000, 32'h0);
    vt[8]  = mk(4'b0101, 32'h0000_6002, 32'h0,        5'd10, 32'h8001_7FFF, 0, 0, 0, K_DV,  32'h0000_8001, 32'h0000_6000, 4'b0000, 32'h0);
    vt[9]  = mk(4'b1010, 32'h0000_7000, 32'hDEAD_BEEF, 5'd0, 32'h0,         0, 2, 1, K_WF,  32'h0,         32'h0000_7000, 4'b1111, 32'hDEAD_BEEF);
    vt[10] = mk(4'b0001, 32'h0000_7003, 32'h0,        5'd2,  32'h0,         0, 0, 0, K_ALE, 32'h0,         32'h0,         4'b0000, 32'h0);
    vt[11] = mk(4'b0011, 32'h0000_8000, 32'h0,        5'd11, 32'hCAFE_F00D, 0, 0, 0, K_DV,  32'hCAFE_F00D, 32'h0000_8000, 4'b0000, 32'h0);
    vt[12] = mk(4'b1010, 32'h0000_9002, 32'h1111_1111, 5'd0, 32'h0,         0, 0, 0, K_ALE, 32'h0,         32'h0,         4'b0000, 32'h0);
    vt[13] = mk(4'b0000, 32'h0000_9002, 32'h0,        5'd12, 32'h00AB_0000, 0, 0, 0, K_DV,  32'hFFFF_FFAB, 32'h0000_9000, 4'b0000, 32'h0);

    // Reset state.
    #2;
    chk("rst_req_valid", 32'(data_req_valid), 32'd0);
    chk("rst_ale", 32'(lsu_except_ale_ls1), 32'd0);
    chk("rst_dv", 32'(lsu_data_valid_ls3), 32'd0);
    chk("rst_wf", 32'(lsu_wr_fin_ls3), 32'd0);
    chk("rst_be", 32'(lsu_except_buserr_ls3), 32'd0);
    chk("rst_rdata", lsu_rdata_ls3, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      $display("vector %0d: op=%b addr=0x%08h", i, vt[i].op, vt[i].addr);
      do_op(vt[i]);
    end

    // Reset while the request is stalled in REQ.
    @(negedge clk);
    lsu_vld_e  = 1'b1;
    lsu_op_e   = 4'b0010;
    lsu_addr_e = 32'h0000_A000;
    lsu_rd_e   = 5'd3;
    @(negedge clk);
    lsu_vld_e = 1'b0;
    @(negedge clk);
    chk("rst_mid_req_valid_before", 32'(data_req_valid), 32'd1);
    #1 reset = 1'b1;
    #1 chk("rst_mid_req_dropped", 32'(data_req_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses_before = pulses;
    @(negedge clk);
    data_rsp_valid = 1'b1;
    data_rsp_rdata = 32'h5555_AAAA;
    @(negedge clk);
    data_rsp_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_pulse_after_reset", 32'(pulses), 32'(pulses_before));
    $display("reset-in-REQ sequence done, pulses=%0d", pulses);

    // Normal operation resumes after the reset.
    do_op(vt[0]);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
